// File: rtl/la_sample_qualifier.sv
// Sample qualifier in front of the logic analyzer core: registers the probed bus and
// strobes cqual only for samples worth storing. Optional build macro: LA_QUAL_DEGLITCH_EN.
module la_sample_qualifier #(
  parameter int DATA_W     = 16,
  parameter int PRESCALE_W = 16,
  parameter int HEARTBEAT  = 255,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [DATA_W-1:0]     chg_mask,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  output logic                  cqual,
  output logic [CNT_W-1:0]      sample_count
);

  localparam logic [1:0] MODE_ALL    = 2'b00;
  localparam logic [1:0] MODE_TICK   = 2'b01;
  localparam logic [1:0] MODE_CHG    = 2'b10;
  localparam logic [1:0] MODE_CHG_HB = 2'b11;

  localparam int              HB_W    = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT - 1);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [HB_W-1:0]       hb_cnt;
  logic [DATA_W-1:0]     last_q;
  logic                  first;

  logic tick;
  logic diff;
  logic change;
  logic heartbeat;
  logic mode_hit;
  logic qual;

  // >= rather than == so a prescale lowered below pre_cnt fires at once instead of wrapping
  always_comb begin
    tick      = (pre_cnt >= prescale);
    diff      = |((data_in ^ last_q) & chg_mask);
    heartbeat = tick && (hb_cnt == HB_LAST);
  end

`ifdef LA_QUAL_DEGLITCH_EN
  logic [DATA_W-1:0] data_in_d;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      data_in_d <= '0;
    end else begin
      data_in_d <= data_in;
    end
  end

  // a change only counts once the new value has been held for two clocks
  always_comb begin
    change = diff && (data_in == data_in_d);
  end
`else
  always_comb begin
    change = diff;
  end
`endif

  always_comb begin
    mode_hit = 1'b0;
    case (mode)
      MODE_ALL:    mode_hit = 1'b1;
      MODE_TICK:   mode_hit = tick;
      MODE_CHG:    mode_hit = change;
      MODE_CHG_HB: mode_hit = change || heartbeat;
      default:     mode_hit = 1'b0;
    endcase
    qual = en && (first || mode_hit);
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      data_out     <= '0;
      cqual        <= 1'b0;
      sample_count <= '0;
      pre_cnt      <= '0;
      hb_cnt       <= '0;
      last_q       <= '0;
      first        <= 1'b1;
    end else begin
      data_out <= data_in;
      cqual    <= qual;
      if (en) begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        if (qual) begin
          first  <= 1'b0;
          last_q <= data_in;
          hb_cnt <= '0;
          if (!(&sample_count)) begin
            sample_count <= sample_count + 1'b1;
          end
        end else if (tick && (hb_cnt != HB_LAST)) begin
          hb_cnt <= hb_cnt + 1'b1;
        end
      end
    end
  end

endmodule
